// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command-line transmitter.
package sd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CRC_REQ,
      CRC_WAIT,
      SHIFT,
      DONE
   } tx_state_e;

   localparam logic START_BIT = 1'b0;
   localparam logic TX_BIT    = 1'b1;
   localparam logic END_BIT   = 1'b1;

   localparam int SD_CMD_W = 48;
   localparam int SD_HDR_W = 40;

   localparam logic [5:0] CMD0  = 6'd0;
   localparam logic [5:0] CMD8  = 6'd8;
   localparam logic [5:0] CMD17 = 6'd17;

   // Host-to-card header: start bit, transmission bit, index, argument.
   function automatic logic [SD_HDR_W-1:0] build_hdr(input logic [5:0]  idx,
                                                     input logic [31:0] arg);
      return {START_BIT, TX_BIT, idx, arg};
   endfunction

endpackage

// File: rtl/sd_cmd_tx_if.sv
// Command request, crc7 hand-off and CMD-line signals of sd_cmd_tx.
interface sd_cmd_tx_if;
   import sd_pkg::*;

   logic                start_i;
   logic [5:0]          cmd_idx_i;
   logic [31:0]         arg_i;
   logic                ready_o;
   logic                tick_i;
   logic                crc_en_o;
   logic [SD_HDR_W-1:0] crc_data_o;
   logic [6:0]          crc_i;
   logic                crc_valid_i;
   logic                cmd_o;
   logic                cmd_oe_o;
   logic                done_o;
   logic                err_o;

   // Transmitter side.
   modport slave (
      input  start_i, cmd_idx_i, arg_i, tick_i, crc_i, crc_valid_i,
      output ready_o, crc_en_o, crc_data_o, cmd_o, cmd_oe_o, done_o, err_o
   );

   // Requester / crc7 / line side.
   modport master (
      output start_i, cmd_idx_i, arg_i, tick_i, crc_i, crc_valid_i,
      input  ready_o, crc_en_o, crc_data_o, cmd_o, cmd_oe_o, done_o, err_o
   );

endinterface

// File: rtl/sd_cmd_tx.sv
// SD command transmitter: builds the 40-bit header, obtains CRC7 from an
// external crc7 block, then shifts the 48-bit token MSB-first on SD bit ticks.
module sd_cmd_tx
   import sd_pkg::*;
#(
   parameter int FRAME_W = 48,
   parameter int HDR_W   = 40,
   parameter int CRC_TO  = 64
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   sd_cmd_tx_if.slave   bus
);

   localparam int               TO_W     = $clog2(CRC_TO);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(CRC_TO - 2);
   localparam logic [TO_W-1:0]  TO_MAX   = '1;
   localparam logic [5:0]       LAST_BIT = 6'(FRAME_W - 1);

   tx_state_e            state;
   logic [5:0]           bit_cnt;
   logic [TO_W-1:0]      to_cnt;
   // Bits still to go after the one currently on cmd_o; ones shift in so the
   // line idles high once the end bit has left.
   logic [FRAME_W-2:0]   frame_rest;

   // Control FSM with registered outputs; the timeout counter value seen in
   // CRC_WAIT is the number of earlier wait cycles, so the check against
   // CRC_TO-2 fires err_o exactly CRC_TO cycles after crc_en_o.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state          <= IDLE;
         bus.ready_o    <= 1'b1;
         bus.crc_en_o   <= 1'b0;
         bus.crc_data_o <= '0;
         bus.cmd_o      <= 1'b1;
         bus.cmd_oe_o   <= 1'b0;
         bus.done_o     <= 1'b0;
         bus.err_o      <= 1'b0;
         bit_cnt        <= '0;
         to_cnt         <= '0;
         frame_rest     <= '1;
      end else begin
         bus.crc_en_o <= 1'b0;
         bus.done_o   <= 1'b0;
         bus.err_o    <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  bus.crc_data_o <= build_hdr(bus.cmd_idx_i, bus.arg_i);
                  bus.crc_en_o   <= 1'b1;
                  bus.ready_o    <= 1'b0;
                  state          <= CRC_REQ;
               end
            end
            CRC_REQ: begin
               to_cnt <= '0;
               state  <= CRC_WAIT;
            end
            CRC_WAIT: begin
               // A valid CRC takes priority over a timeout in the same cycle.
               if (bus.crc_valid_i) begin
                  bus.cmd_o    <= bus.crc_data_o[HDR_W-1];
                  frame_rest   <= {bus.crc_data_o[HDR_W-2:0], bus.crc_i, END_BIT};
                  bus.cmd_oe_o <= 1'b1;
                  bit_cnt      <= '0;
                  state        <= SHIFT;
               end else begin
                  if (to_cnt != TO_MAX) begin
                     to_cnt <= to_cnt + TO_W'(1);
                  end
                  if (to_cnt == TO_LAST) begin
                     bus.err_o   <= 1'b1;
                     bus.ready_o <= 1'b1;
                     state       <= IDLE;
                  end
               end
            end
            SHIFT: begin
               if (bus.tick_i) begin
                  if (bit_cnt == LAST_BIT) begin
                     bus.cmd_o    <= 1'b1;
                     bus.cmd_oe_o <= 1'b0;
                     bus.done_o   <= 1'b1;
                     state        <= DONE;
                  end else begin
                     bus.cmd_o  <= frame_rest[FRAME_W-2];
                     frame_rest <= {frame_rest[FRAME_W-3:0], 1'b1};
                     bit_cnt    <= bit_cnt + 6'd1;
                  end
               end
            end
            DONE: begin
               bus.ready_o <= 1'b1;
               state       <= IDLE;
            end
            default: begin
               bus.ready_o  <= 1'b1;
               bus.cmd_o    <= 1'b1;
               bus.cmd_oe_o <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Bench for sd_cmd_tx: behavioural crc7 responder, bit-tick generator and a
// line monitor; expected tokens come from a polynomial CRC7 reference.
module tb_sd_cmd_tx;
   import sd_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sd_cmd_tx_if bus();

   sd_cmd_tx #(.FRAME_W(48), .HDR_W(40), .CRC_TO(64)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   // Environment knobs
   int crc_lat  = 1;
   bit resp_en  = 1'b1;
   int tick_per = 1;

   // Monitor state
   logic [47:0] cap;
   int          n_cap, n_done, n_err, n_en, n_oe;
   bit          hold_bad;
   longint      cyc = 0, en_cyc = 0, err_cyc = 0;
   logic        prev_oe = 1'b0, prev_tick = 1'b0, prev_cmd = 1'b1;

   // CRC7, generator x^7 + x^3 + 1, processed MSB first.
   function automatic logic [6:0] ref_crc7(input logic [39:0] hdr);
      logic [6:0] c = 7'd0;
      logic       fb;
      for (int i = 39; i >= 0; i--) begin
         fb = hdr[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] hdr = {1'b0, 1'b1, idx, arg};
      return {hdr, ref_crc7(hdr), 1'b1};
   endfunction

   // Bit-tick strobe, one cycle every tick_per cycles.
   initial begin : tick_gen
      int tcnt = 0;
      bus.tick_i = 1'b0;
      forever begin
         @(posedge clk); #1;
         tcnt++;
         if (tcnt >= tick_per) begin
            bus.tick_i = 1'b1;
            tcnt = 0;
         end else begin
            bus.tick_i = 1'b0;
         end
      end
   end

   // crc7 stand-in: valid appears crc_lat cycles after the crc_en_o cycle.
   initial begin : crc_resp
      bus.crc_valid_i = 1'b0;
      bus.crc_i = 7'd0;
      forever begin
         @(negedge clk);
         if (resp_en && bus.crc_en_o) begin
            repeat (crc_lat) @(posedge clk);
            #1;
            bus.crc_i = ref_crc7(bus.crc_data_o);
            bus.crc_valid_i = 1'b1;
            @(posedge clk); #1;
            bus.crc_valid_i = 1'b0;
            bus.crc_i = 7'($urandom);
         end
      end
   end

   // Line monitor: capture on each tick while driven, count pulses, check hold.
   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.cmd_oe_o && bus.tick_i) begin
            cap = {cap[46:0], bus.cmd_o};
            n_cap++;
         end
         if (bus.cmd_oe_o) n_oe++;
         if (prev_oe && bus.cmd_oe_o && !prev_tick && (bus.cmd_o !== prev_cmd)) hold_bad = 1'b1;
         if (bus.done_o) n_done++;
         if (bus.err_o) begin n_err++; err_cyc = cyc; end
         if (bus.crc_en_o) begin n_en++; en_cyc = cyc; end
         prev_oe = bus.cmd_oe_o;
         prev_tick = bus.tick_i;
         prev_cmd = bus.cmd_o;
      end
   end

   task automatic clear_mon();
      cap = '0; n_cap = 0; n_done = 0; n_err = 0; n_en = 0; n_oe = 0; hold_bad = 1'b0;
   endtask

   task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           output logic [39:0] hdr, output bit ok);
      ok = 1'b0;
      hdr = '0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (bus.ready_o) ok = 1'b1;
      end
      if (!ok) return;
      @(posedge clk); #1;
      bus.start_i = 1'b1; bus.cmd_idx_i = idx; bus.arg_i = arg;
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.cmd_idx_i = 6'($urandom); bus.arg_i = $urandom;
      @(negedge clk); #1;
      hdr = bus.crc_data_o;
   endtask

   task automatic wait_end(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 800 && !ok; i++) begin
         @(negedge clk); #1;
         if (bus.done_o || bus.err_o) ok = 1'b1;
      end
      @(negedge clk); #1;
   endtask

   task automatic test_reset();
      vectors++;
      if (bus.ready_o !== 1'b1 || bus.crc_en_o !== 1'b0 || bus.crc_data_o !== 40'h0) begin
         miscompares++;
         $display("FAIL reset_ctrl: ready=%b crc_en=%b crc_data=%h, want 1 0 0",
                  bus.ready_o, bus.crc_en_o, bus.crc_data_o);
      end
      vectors++;
      if (bus.cmd_o !== 1'b1 || bus.cmd_oe_o !== 1'b0 || bus.done_o !== 1'b0 || bus.err_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_line: cmd=%b oe=%b done=%b err=%b, want 1 0 0 0",
                  bus.cmd_o, bus.cmd_oe_o, bus.done_o, bus.err_o);
      end
   endtask

   task automatic test_cmd0();
      logic [39:0] hdr; bit ok;
      tick_per = 1; crc_lat = 3; clear_mon();
      send_cmd(CMD0, 32'h0, hdr, ok);
      wait_end(ok);
      vectors++;
      if (hdr !== 40'h4000000000) begin
         miscompares++; $display("FAIL cmd0_hdr: got %h want 4000000000", hdr);
      end
      vectors++;
      if (!ok || cap !== 48'h400000000095 || n_cap != 48) begin
         miscompares++; $display("FAIL cmd0_frame: got %h (%0d bits) want 400000000095 (48)", cap, n_cap);
      end
      vectors++;
      if (n_done != 1 || n_err != 0) begin
         miscompares++; $display("FAIL cmd0_done: done=%0d err=%0d want 1 0", n_done, n_err);
      end
   endtask

   task automatic test_cmd8();
      logic [39:0] hdr; bit ok;
      tick_per = 2; crc_lat = 5; clear_mon();
      send_cmd(CMD8, 32'h000001AA, hdr, ok);
      wait_end(ok);
      vectors++;
      if (!ok || cap !== 48'h48000001AA87) begin
         miscompares++; $display("FAIL cmd8_frame: got %h want 48000001aa87", cap);
      end
      vectors++;
      if (n_cap != 48 || hold_bad) begin
         miscompares++; $display("FAIL cmd8_oe_ticks: got %0d ticks hold_bad=%b want 48 0", n_cap, hold_bad);
      end
      vectors++;
      if (bus.ready_o !== 1'b1 || bus.cmd_o !== 1'b1 || bus.cmd_oe_o !== 1'b0) begin
         miscompares++; $display("FAIL cmd8_idle: ready=%b cmd=%b oe=%b want 1 1 0",
                                 bus.ready_o, bus.cmd_o, bus.cmd_oe_o);
      end
   endtask

   task automatic test_cmd17_busy_start();
      logic [39:0] hdr; bit ok; bit seen;
      tick_per = 4; crc_lat = 2; clear_mon();
      send_cmd(CMD17, 32'h0, hdr, ok);
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk); #1;
         if (n_cap >= 10) seen = 1'b1;
      end
      @(posedge clk); #1;
      bus.start_i = 1'b1; bus.cmd_idx_i = CMD0; bus.arg_i = 32'hFFFF_FFFF;
      @(negedge clk); #1;
      vectors++;
      if (!seen || bus.ready_o !== 1'b0) begin
         miscompares++; $display("FAIL cmd17_busy_ready: got %b want 0", bus.ready_o);
      end
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      wait_end(ok);
      repeat (5) @(negedge clk);
      #1;
      vectors++;
      if (!ok || cap !== 48'h510000000055) begin
         miscompares++; $display("FAIL cmd17_frame: got %h want 510000000055", cap);
      end
      vectors++;
      if (n_en != 1 || n_done != 1 || bus.ready_o !== 1'b1) begin
         miscompares++; $display("FAIL cmd17_no_queue: crc_en=%0d done=%0d ready=%b want 1 1 1",
                                 n_en, n_done, bus.ready_o);
      end
   endtask

   task automatic test_timeout();
      logic [39:0] hdr; bit ok;
      resp_en = 1'b0; tick_per = 1; clear_mon();
      send_cmd(CMD8, 32'h12345678, hdr, ok);
      wait_end(ok);
      vectors++;
      if (!ok || n_err != 1 || (err_cyc - en_cyc) != 64) begin
         miscompares++; $display("FAIL timeout_err: err=%0d after %0d cycles want 1 after 64",
                                 n_err, int'(err_cyc - en_cyc));
      end
      vectors++;
      if (n_oe != 0 || n_done != 0 || bus.ready_o !== 1'b1) begin
         miscompares++; $display("FAIL timeout_line: oe_cycles=%0d done=%0d ready=%b want 0 0 1",
                                 n_oe, n_done, bus.ready_o);
      end
      resp_en = 1'b1;
   endtask

   task automatic test_valid_wins();
      logic [39:0] hdr; bit ok;
      tick_per = 3; crc_lat = 63; clear_mon();
      send_cmd(6'd55, 32'hDEADBEEF, hdr, ok);
      wait_end(ok);
      vectors++;
      if (!ok || n_err != 0 || cap !== ref_frame(6'd55, 32'hDEADBEEF)) begin
         miscompares++; $display("FAIL valid_wins: got %h err=%0d want %h err=0",
                                 cap, n_err, ref_frame(6'd55, 32'hDEADBEEF));
      end
   endtask

   task automatic test_random();
      logic [39:0] hdr; logic [5:0] idx; logic [31:0] arg; bit ok;
      for (int n = 0; n < 8; n++) begin
         idx = 6'($urandom); arg = $urandom;
         crc_lat = int'($urandom_range(1, 40));
         tick_per = int'($urandom_range(1, 5));
         clear_mon();
         send_cmd(idx, arg, hdr, ok);
         wait_end(ok);
         vectors++;
         if (!ok || hdr !== {2'b01, idx, arg} || cap !== ref_frame(idx, arg) ||
             n_cap != 48 || n_done != 1 || hold_bad) begin
            miscompares++;
            $display("FAIL random_%0d: hdr=%h frame=%h bits=%0d done=%0d hold_bad=%b want frame %h",
                     n, hdr, cap, n_cap, n_done, hold_bad, ref_frame(idx, arg));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [39:0] hdr; bit ok; bit seen;
      tick_per = 2; crc_lat = 4; clear_mon();
      send_cmd(CMD8, 32'h000001AA, hdr, ok);
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk); #1;
         if (n_cap >= 20) seen = 1'b1;
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (!seen || bus.cmd_o !== 1'b1 || bus.cmd_oe_o !== 1'b0 || bus.ready_o !== 1'b1 ||
          bus.crc_data_o !== 40'h0) begin
         miscompares++; $display("FAIL midreset_async: cmd=%b oe=%b ready=%b crc_data=%h want 1 0 1 0",
                                 bus.cmd_o, bus.cmd_oe_o, bus.ready_o, bus.crc_data_o);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if (n_done != 0 || n_err != 0) begin
         miscompares++; $display("FAIL midreset_pulses: done=%0d err=%0d want 0 0", n_done, n_err);
      end
      tick_per = 1; crc_lat = 2; clear_mon();
      send_cmd(CMD0, 32'h0, hdr, ok);
      wait_end(ok);
      vectors++;
      if (!ok || cap !== 48'h400000000095 || n_done != 1) begin
         miscompares++; $display("FAIL midreset_next: got %h done=%0d want 400000000095 1", cap, n_done);
      end
   endtask

   initial begin : main
      bus.start_i = 1'b0; bus.cmd_idx_i = '0; bus.arg_i = '0;
      clear_mon();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      test_cmd0();
      test_cmd8();
      test_cmd17_busy_start();
      test_timeout();
      test_valid_wins();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sd_cmd_tx.md
Name: sd_cmd_tx

Overview:
SD command-line transmitter that sits directly downstream of crc7. It accepts a command index and a 32-bit argument, and hands the 40-bit header to crc7. It then appends the returned CRC7 and the end bit to form the 48-bit SD command token. The token is shifted MSB-first onto the CMD line, one bit per SD bit-tick.

Parameters:
- FRAME_W, 48, total command token width in bits.
- HDR_W, 40, header width presented to crc7.
- CRC_TO, 64, maximum clk_i cycles to wait for crc_valid_i before aborting.

Ports:
- clk_i, input, 1, system clock.
- rst_ni, input, 1, asynchronous active-low reset.
- start_i, input, 1, request to send a command; accepted only when ready_o=1.
- cmd_idx_i, input, 6, command index, sampled on the accepted start.
- arg_i, input, 32, command argument, sampled on the accepted start.
- ready_o, output, 1, high in IDLE only.
- tick_i, input, 1, one-cycle strobe marking each SD bit period (falling SD clock edge).
- crc_en_o, output, 1, one-cycle pulse that starts crc7.
- crc_data_o, output, 40, header {1'b0, 1'b1, cmd_idx, arg} driven to crc7 data_i.
- crc_i, input, 7, CRC7 result from crc7 crc_o.
- crc_valid_i, input, 1, crc7 crc_valid_o.
- cmd_o, output, 1, serial CMD line data.
- cmd_oe_o, output, 1, CMD line output enable (high only while shifting).
- done_o, output, 1, one-cycle pulse after the last bit is sent.
- err_o, output, 1, one-cycle pulse on CRC timeout.

Behaviour:
- Reset (rst_ni=0, asynchronous) forces:
  - state IDLE, ready_o=1, crc_en_o=0, crc_data_o=0;
  - cmd_o=1, cmd_oe_o=0, done_o=0, err_o=0;
  - bit counter and timeout counter cleared.
- Reset asserted mid-operation aborts immediately. No done_o or err_o is issued. The next command needs a fresh start_i after rst_ni deasserts.
- IDLE:
  - On start_i=1, latch crc_data_o = {0, 1, cmd_idx_i, arg_i} and go to CRC_REQ.
  - start_i while not IDLE is ignored (no queueing).
- CRC_REQ: assert crc_en_o for exactly one cycle, clear the timeout counter, go to CRC_WAIT.
- CRC_WAIT:
  - crc_data_o is held stable throughout.
  - On crc_valid_i=1, latch frame = {crc_data_o, crc_i, 1'b1} and go to SHIFT.
  - Otherwise increment the timeout counter. When it reaches CRC_TO-1 without valid, pulse err_o and go to IDLE.
  - If crc_valid_i arrives on the same cycle as the timeout, valid wins.
- SHIFT:
  - cmd_oe_o=1 and cmd_o=frame[47] from the first SHIFT cycle.
  - On each tick_i: shift frame left by one and increment bit_cnt (0..47).
  - On tick_i with bit_cnt==47: go to DONE (cmd_oe_o drops in DONE).
  - Cycles without tick_i hold cmd_o.
  - A tick_i in the same cycle as entry into SHIFT is not counted. The first bit is always held for at least one full tick period.
- DONE: done_o=1 for one cycle, cmd_o=1, cmd_oe_o=0, then go to IDLE.
- Latency from start_i to first bit on cmd_o: 2 cycles plus crc7 latency plus 1 cycle.
- Bit order: start(0), transmission(1), index[5:0], arg[31:0], crc[6:0], end(1).
- cmd_o is registered (no combinational path from inputs).
- Counters:
  - bit_cnt is 6 bits; no wrap is possible because the exit occurs at 47.
  - The timeout counter is $clog2(CRC_TO) bits and saturates.

Decomposition:
- Package sd_pkg holds:
  - state enum tx_state_e {IDLE, CRC_REQ, CRC_WAIT, SHIFT, DONE};
  - constants START_BIT=0, TX_BIT=1, END_BIT=1, SD_CMD_W=48, SD_HDR_W=40;
  - command index constants CMD0=6'd0, CMD8=6'd8, CMD17=6'd17.
- No sub-module: crc7 is instantiated beside this block at the parent level, not inside it.

Test Plan:
- CMD0, arg 0x00000000, crc7 model returns 0x4A:
  - crc_data_o = 0x4000000000;
  - serial capture on tick_i = 0x400000000095 (48 bits);
  - done_o pulses once.
- CMD8, arg 0x000001AA, crc returns 0x43 -> serial capture 0x48000001AA87; cmd_oe_o high for exactly 48 ticks.
- CMD17, arg 0, crc 0x2A, tick_i every 4 cycles -> capture 0x510000000055; start_i pulsed mid-shift is ignored and ready_o stays 0.
- crc_valid_i never asserted -> err_o pulses once, 64 cycles after crc_en_o; cmd_oe_o never rises; ready_o=1 afterwards.
- rst_ni low after 20 ticks of CMD8 -> cmd_o=1, cmd_oe_o=0 asynchronously; no done_o; the next CMD0 frame is transmitted correctly.
